// File: rtl/fac_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : fac_bus_master
// Brief    : Runs one factorial-core job over the Top bus per host start pulse.
//            Optional interrupt-wait timeout enabled by defining FAC_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fac_bus_master #(
    parameter logic [15:0] BASE_ADDR      = 16'h7000,
    parameter int          READ_LATENCY   = 1,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [63:0]   operand,
    output logic          busy,
    output logic          done,
    output logic [127:0]  result,
    output logic          error,
    output logic          m_req,
    output logic          m_wr,
    output logic [15:0]   m_addr,
    output logic [63:0]   m_dout,
    input  logic          m_grant,
    input  logic [63:0]   m_din,
    input  logic          interrupt
);

    localparam logic [15:0] c_addr_opstart = BASE_ADDR + 16'h0000;
    localparam logic [15:0] c_addr_opclear = BASE_ADDR + 16'h0008;
    localparam logic [15:0] c_addr_intren  = BASE_ADDR + 16'h0018;
    localparam logic [15:0] c_addr_operand = BASE_ADDR + 16'h0020;
    localparam logic [15:0] c_addr_res_h   = BASE_ADDR + 16'h0028;
    localparam logic [15:0] c_addr_res_l   = BASE_ADDR + 16'h0030;
    localparam logic [1:0]  c_rd_lat       = 2'(READ_LATENCY);
    localparam logic [31:0] c_tmo_last     = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_REQ  = 4'd1,
        S_CLR1 = 4'd2,
        S_CLR0 = 4'd3,
        S_WOP  = 4'd4,
        S_WIE  = 4'd5,
        S_WST  = 4'd6,
        S_WINT = 4'd7,
        S_RDH  = 4'd8,
        S_RDL  = 4'd9,
        S_ACK1 = 4'd10,
        S_ACK0 = 4'd11,
        S_FIN  = 4'd12
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_busy,      w_busy_nxt;
    logic           r_done,      w_done_nxt;
    logic [127:0]   r_result,    w_result_nxt;
    logic           r_error,     w_error_nxt;
    logic           r_m_req,     w_req_nxt;
    logic           r_m_wr,      w_wr_nxt;
    logic [15:0]    r_m_addr,    w_addr_nxt;
    logic [63:0]    r_m_dout,    w_dout_nxt;
    logic [63:0]    r_operand,   w_operand_nxt;
    logic [63:0]    r_res_h,     w_res_h_nxt;
    logic [63:0]    r_res_l,     w_res_l_nxt;
    logic           r_rd_pend,   w_rd_pend_nxt;
    logic [1:0]     r_rd_cnt,    w_rd_cnt_nxt;
    logic           r_timed_out, w_timed_out_nxt;

    logic           w_in_read;
    logic           w_rd_fire;
    logic           w_tmo_hit;

    // ------------------------------------------------------------------------
    // Interrupt-wait timeout
    // ------------------------------------------------------------------------
`ifdef FAC_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_WINT) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign w_unused_tmo = ^c_tmo_last;
`endif

    // ------------------------------------------------------------------------
    // Read handshake: address phase needs grant, data arrives c_rd_lat edges later
    // ------------------------------------------------------------------------
    assign w_in_read = (r_state == S_RDH) || (r_state == S_RDL);

    always_comb begin
        w_rd_fire     = 1'b0;
        w_rd_pend_nxt = r_rd_pend;
        w_rd_cnt_nxt  = r_rd_cnt;
        if (w_in_read) begin
            if (r_rd_pend) begin
                if (r_rd_cnt == c_rd_lat) begin
                    w_rd_fire     = 1'b1;
                    w_rd_pend_nxt = 1'b0;
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + 2'd1;
                end
            end else if (m_grant) begin
                if (c_rd_lat == 2'd0) begin
                    w_rd_fire = 1'b1;
                end else begin
                    w_rd_pend_nxt = 1'b1;
                    w_rd_cnt_nxt  = 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and next registered outputs; bus fields describe the next state's cycle
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_result_nxt    = r_result;
        w_error_nxt     = r_error;
        w_req_nxt       = r_m_req;
        w_wr_nxt        = r_m_wr;
        w_addr_nxt      = r_m_addr;
        w_dout_nxt      = r_m_dout;
        w_operand_nxt   = r_operand;
        w_res_h_nxt     = r_res_h;
        w_res_l_nxt     = r_res_l;
        w_timed_out_nxt = r_timed_out;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_REQ;
                    w_busy_nxt      = 1'b1;
                    w_error_nxt     = 1'b0;
                    w_timed_out_nxt = 1'b0;
                    w_operand_nxt   = operand;
                    w_req_nxt       = 1'b1;
                    w_wr_nxt        = 1'b0;
                    w_addr_nxt      = c_addr_opclear;
                    w_dout_nxt      = 64'd0;
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    w_state_nxt = S_CLR1;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = c_addr_opclear;
                    w_dout_nxt  = 64'd1;
                end
            end
            S_CLR1: begin
                if (m_grant) begin
                    w_state_nxt = S_CLR0;
                    w_addr_nxt  = c_addr_opclear;
                    w_dout_nxt  = 64'd0;
                end
            end
            S_CLR0: begin
                if (m_grant) begin
                    w_state_nxt = S_WOP;
                    w_addr_nxt  = c_addr_operand;
                    w_dout_nxt  = r_operand;
                end
            end
            S_WOP: begin
                if (m_grant) begin
                    w_state_nxt = S_WIE;
                    w_addr_nxt  = c_addr_intren;
                    w_dout_nxt  = 64'd1;
                end
            end
            S_WIE: begin
                if (m_grant) begin
                    w_state_nxt = S_WST;
                    w_addr_nxt  = c_addr_opstart;
                    w_dout_nxt  = 64'd1;
                end
            end
            S_WST: begin
                if (m_grant) begin
                    w_state_nxt = S_WINT;
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = c_addr_res_h;
                    w_dout_nxt  = 64'd0;
                end
            end
            S_WINT: begin
                if (interrupt) begin
                    w_state_nxt = S_RDH;
                end else if (w_tmo_hit) begin
                    w_state_nxt     = S_ACK1;
                    w_timed_out_nxt = 1'b1;
                    w_wr_nxt        = 1'b1;
                    w_addr_nxt      = c_addr_opclear;
                    w_dout_nxt      = 64'd1;
                end
            end
            S_RDH: begin
                if (w_rd_fire) begin
                    w_state_nxt = S_RDL;
                    w_res_h_nxt = m_din;
                    w_addr_nxt  = c_addr_res_l;
                end
            end
            S_RDL: begin
                if (w_rd_fire) begin
                    w_state_nxt = S_ACK1;
                    w_res_l_nxt = m_din;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = c_addr_opclear;
                    w_dout_nxt  = 64'd1;
                end
            end
            S_ACK1: begin
                if (m_grant) begin
                    w_state_nxt = S_ACK0;
                    w_addr_nxt  = c_addr_opclear;
                    w_dout_nxt  = 64'd0;
                end
            end
            S_ACK0: begin
                if (m_grant) begin
                    w_state_nxt = S_FIN;
                    w_req_nxt   = 1'b0;
                    w_wr_nxt    = 1'b0;
                    w_addr_nxt  = 16'd0;
                    w_dout_nxt  = 64'd0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_error_nxt = r_timed_out;
                    // A timed-out job leaves the previous result visible.
                    if (!r_timed_out) begin
                        w_result_nxt = {r_res_h, r_res_l};
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
                w_wr_nxt    = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_error     <= 1'b0;
            r_m_req     <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_addr    <= '0;
            r_m_dout    <= '0;
            r_operand   <= '0;
            r_res_h     <= '0;
            r_res_l     <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_cnt    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_result    <= w_result_nxt;
            r_error     <= w_error_nxt;
            r_m_req     <= w_req_nxt;
            r_m_wr      <= w_wr_nxt;
            r_m_addr    <= w_addr_nxt;
            r_m_dout    <= w_dout_nxt;
            r_operand   <= w_operand_nxt;
            r_res_h     <= w_res_h_nxt;
            r_res_l     <= w_res_l_nxt;
            r_rd_pend   <= w_rd_pend_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_timed_out <= w_timed_out_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign error  = r_error;
    assign m_req  = r_m_req;
    assign m_wr   = r_m_wr;
    assign m_addr = r_m_addr;
    assign m_dout = r_m_dout;

endmodule
`default_nettype wire

// File: tb/tb_fac_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_fac_bus_master
// Brief    : Scoreboard bench for fac_bus_master with a behavioural factorial core.
// Revision : 1.0  initial release
// ============================================================================
module tb_fac_bus_master;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [63:0]   operand   = '0;
    logic          m_grant   = 1'b1;
    logic [63:0]   m_din     = '0;
    logic          interrupt = 1'b0;
    logic          busy, done, error, m_req, m_wr;
    logic [127:0]  result;
    logic [15:0]   m_addr;
    logic [63:0]   m_dout;

    typedef struct {
        logic [127:0] res;
        logic         err;
    } exp_res_t;

    logic [79:0]   exp_wr[$];
    exp_res_t      exp_res[$];
    int            total    = 0;
    int            bad      = 0;
    int            done_cnt = 0;

    always #5 clk = ~clk;

    fac_bus_master #(
        .BASE_ADDR      (16'h7000),
        .READ_LATENCY   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .operand   (operand),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .error     (error),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din),
        .interrupt (interrupt)
    );

    // Behavioural factorial core on the bus: 20-cycle compute, level interrupt.
    logic [63:0]  core_op   = '0;
    logic         core_ie   = 1'b0;
    logic [127:0] core_res  = '0;
    logic         core_busy = 1'b0;
    int           core_cnt  = 0;
    logic         irq_mask  = 1'b0;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    always @(posedge clk) begin
        if (m_req && m_wr && m_grant) begin
            case (m_addr)
                16'h7008: if (m_dout[0]) begin
                    core_busy <= 1'b0;
                    interrupt <= 1'b0;
                    core_res  <= '0;
                end
                16'h7018: core_ie <= m_dout[0];
                16'h7020: core_op <= m_dout;
                16'h7000: if (m_dout[0]) begin
                    core_busy <= 1'b1;
                    core_cnt  <= 20;
                end
                default: ;
            endcase
        end else if (core_busy) begin
            if (core_cnt == 0) begin
                core_busy <= 1'b0;
                core_res  <= fact(core_op);
                interrupt <= core_ie && !irq_mask;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        m_din <= (m_addr == 16'h7028) ? core_res[127:64] :
                 (m_addr == 16'h7030) ? core_res[63:0]   : 64'd0;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completing write and every done pulse.
    always @(negedge clk) begin
        if (reset_n && m_req && m_wr && m_grant) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", m_addr, m_dout);
            end else begin
                check("bus_write", {m_addr, m_dout}, exp_wr.pop_front());
            end
        end
        if (reset_n && done) begin
            done_cnt++;
            if (exp_res.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got result %h expected no done", result);
            end else begin
                exp_res_t e;
                e = exp_res.pop_front();
                check("result", result, e.res);
                check("error", error, e.err);
                check("busy_at_done", busy, 1'b0);
                check("req_at_done", m_req, 1'b0);
            end
        end
    end

    task automatic push_seq(input logic [63:0] op, input bit full);
        exp_wr.push_back({16'h7008, 64'd1});
        exp_wr.push_back({16'h7008, 64'd0});
        exp_wr.push_back({16'h7020, op});
        exp_wr.push_back({16'h7018, 64'd1});
        exp_wr.push_back({16'h7000, 64'd1});
        if (full) begin
            exp_wr.push_back({16'h7008, 64'd1});
            exp_wr.push_back({16'h7008, 64'd0});
        end
    endtask

    task automatic push_res(input logic [127:0] res, input logic err);
        exp_res_t e;
        e.res = res;
        e.err = err;
        exp_res.push_back(e);
    endtask

    task automatic issue(input logic [63:0] op);
        @(posedge clk); #1;
        operand = op;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        operand = 64'hDEAD_BEEF_0BAD_F00D;
        check("busy_after_start", busy, 1'b1);
        check("req_after_start", m_req, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected one", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_req", m_req, 1'b0);
        check("rst_wr", m_wr, 1'b0);
        check("rst_addr", m_addr, 16'd0);
        check("rst_dout", m_dout, 64'd0);
        check("rst_result", result, 128'd0);
        check("rst_error", error, 1'b0);
        reset_n = 1'b1;

        // 5! = 120
        push_seq(64'd5, 1'b1);
        push_res(128'd120, 1'b0);
        issue(64'd5);
        wait_done(200);

        // Abort in WINT with a one-cycle reset
        push_seq(64'd3, 1'b0);
        issue(64'd3);
        n = 0;
        while (!(busy && !m_wr && m_addr == 16'h7028) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_wint", {busy, m_wr, m_addr}, {1'b1, 1'b0, 16'h7028});
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_req", m_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 128'd0);
        reset_n = 1'b1;
        check("abort_writes_left", exp_wr.size(), 0);

        // 0! and 1! back to back
        push_seq(64'd0, 1'b1);
        push_res(128'd1, 1'b0);
        issue(64'd0);
        wait_done(200);
        push_seq(64'd1, 1'b1);
        push_res(128'd1, 1'b0);
        issue(64'd1);
        wait_done(200);

        // 21! spills into the upper word; a start while busy must be ignored
        push_seq(64'd21, 1'b1);
        push_res({64'h2, 64'hC5077D36B8C40000}, 1'b0);
        issue(64'd21);
        repeat (3) @(posedge clk);
        #1;
        operand = 64'd9;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        wait_done(200);

        // Grant withdrawn for three edges while the operand write is presented
        push_seq(64'd6, 1'b1);
        push_res(128'd720, 1'b0);
        issue(64'd6);
        n = 0;
        while (!(m_wr && m_addr == 16'h7008 && m_dout == 64'd0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        m_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", m_addr, 16'h7020);
            check("stall_dout", m_dout, 64'd6);
            check("stall_req_wr", {m_req, m_wr}, 2'b11);
            @(posedge clk); #1;
        end
        m_grant = 1'b1;
        wait_done(200);

`ifdef FAC_TIMEOUT_EN
        // Interrupt never arrives: timeout skips the reads, keeps the old result
        irq_mask = 1'b1;
        push_seq(64'd7, 1'b1);
        push_res(128'd720, 1'b1);
        issue(64'd7);
        wait_done(200);
        irq_mask = 1'b0;
        push_seq(64'd5, 1'b1);
        push_res(128'd120, 1'b0);
        issue(64'd5);
        wait_done(200);
`endif

        repeat (5) @(posedge clk);
        check("writes_left", exp_wr.size(), 0);
        check("results_left", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
